// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD host controller: FSM state encoding,
// default widths/limits and result status codes.
package gcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } host_state_e;

  localparam int DEF_W       = 32;
  localparam int DEF_TIMEOUT = 4096;
  localparam int DEF_TW      = 13;
  localparam int DEF_CW      = 16;

  localparam logic RES_OK      = 1'b0;
  localparam logic RES_TIMEOUT = 1'b1;

endpackage

// File: rtl/gcd_host.sv
// Host-side controller for the GCD engine: accepts operand pairs, launches one
// engine run per pair (or bypasses zero operands), and returns the result.
module gcd_host
  import gcd_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TW      = DEF_TW,
  parameter int CW      = DEF_CW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [W-1:0]  op_a,
  input  logic [W-1:0]  op_b,
  input  logic          op_valid,
  output logic          op_ready,
  output logic [W-1:0]  res_data,
  output logic          res_err,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  gcd_a,
  output logic [W-1:0]  gcd_b,
  output logic          gcd_start,
  input  logic [W-1:0]  gcd_result,
  input  logic          gcd_done,
  output logic          busy,
  output logic [CW-1:0] txn_count
);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  host_state_e   state_q, state_d;
  logic [W-1:0]  gcd_a_q, gcd_a_d;
  logic [W-1:0]  gcd_b_q, gcd_b_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic          res_err_q, res_err_d;
  logic          res_valid_q, res_valid_d;
  logic          gcd_start_q, gcd_start_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] txn_q, txn_d;
  logic          zero_operand;

  // The engine never terminates on a zero operand, so such pairs are answered locally.
  assign zero_operand = (op_a == '0) || (op_b == '0);

  always_comb begin
    state_d    = state_q;
    gcd_a_d    = gcd_a_q;
    gcd_b_d    = gcd_b_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    timer_d    = timer_q;
    txn_d      = txn_q;

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          gcd_a_d = op_a;
          gcd_b_d = op_b;
          if (zero_operand) begin
            res_data_d = op_a | op_b;
            res_err_d  = RES_OK;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        // A done arriving on the last permitted cycle still counts as success.
        if (gcd_done) begin
          res_data_d = gcd_result;
          res_err_d  = RES_OK;
          state_d    = ST_RESP;
        end else if (timer_q == TIMER_LAST) begin
          res_data_d = '0;
          res_err_d  = RES_TIMEOUT;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          txn_d   = txn_q + CW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    gcd_start_d = (state_d == ST_ISSUE);
    res_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      gcd_start_q <= 1'b0;
      timer_q     <= '0;
      txn_q       <= '0;
    end else begin
      state_q     <= state_d;
      gcd_a_q     <= gcd_a_d;
      gcd_b_q     <= gcd_b_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      gcd_start_q <= gcd_start_d;
      timer_q     <= timer_d;
      txn_q       <= txn_d;
    end
  end

  assign op_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign gcd_a     = gcd_a_q;
  assign gcd_b     = gcd_b_q;
  assign gcd_start = gcd_start_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign res_valid = res_valid_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_gcd_host.sv
// Self-checking bench for gcd_host: behavioural engine with programmable done
// latency, a transaction-level reference model, directed and random runs.
module tb_gcd_host;

  localparam int W   = 32;
  localparam int TMO = 16;
  localparam int TW  = 13;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [W-1:0]  res_data;
  logic          res_err;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  gcd_a;
  logic [W-1:0]  gcd_b;
  logic          gcd_start;
  logic [W-1:0]  gcd_result = '0;
  logic          gcd_done = 1'b0;
  logic          busy;
  logic [CW-1:0] txn_count;

  gcd_host #(.W(W), .TIMEOUT(TMO), .TW(TW), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .res_data(res_data), .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready),
    .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_start(gcd_start),
    .gcd_result(gcd_result), .gcd_done(gcd_done),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference GCD: Euclid by remainder.
  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine's own arithmetic: binary (Stein) GCD.
  function automatic logic [W-1:0] eng_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    int sh;
    if (a == '0) return b;
    if (b == '0) return a;
    x = a;
    y = b;
    sh = 0;
    while (((x | y) & 1) == 0) begin
      x = x >> 1;
      y = y >> 1;
      sh++;
    end
    while ((x & 1) == 0) x = x >> 1;
    while (y != '0) begin
      while ((y & 1) == 0) y = y >> 1;
      if (x > y) begin
        t = x;
        x = y;
        y = t;
      end
      y = y - x;
    end
    return x << sh;
  endfunction

  // Behavioural engine: done rises eng_lat cycles after the start cycle; 0 = never.
  int eng_lat = 1;
  int eng_cnt = 0;
  int start_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (gcd_start === 1'b1) begin
      start_cnt++;
      eng_cnt    = eng_lat;
      gcd_done   = 1'b0;
      gcd_result = eng_gcd(gcd_a, gcd_b);
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) gcd_done = 1'b1;
    end
  end

  // Transaction-level model: when the result must appear and what it must be.
  logic          m_active = 1'b0;
  logic          m_byp = 1'b0;
  logic          m_err = 1'b0;
  logic          m_vld;
  logic [W-1:0]  m_a = '0;
  logic [W-1:0]  m_b = '0;
  logic [W-1:0]  m_data = '0;
  logic [CW-1:0] m_txn = '0;
  int            m_acc = 0;
  int            m_resp_at = 0;
  int            cyc = 0;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      m_active = 1'b0;
      m_txn    = '0;
      m_a      = '0;
      m_b      = '0;
    end else begin
      m_vld = m_active && (cyc >= m_resp_at);
      chk("op_ready", 64'(op_ready), 64'(!m_active));
      chk("busy", 64'(busy), 64'(m_active));
      chk("res_valid", 64'(res_valid), 64'(m_vld));
      if (m_vld) begin
        chk("res_data", 64'(res_data), 64'(m_data));
        chk("res_err", 64'(res_err), 64'(m_err));
      end
      chk("gcd_start", 64'(gcd_start), 64'(m_active && !m_byp && (cyc == m_acc + 1)));
      chk("txn_count", 64'(txn_count), 64'(m_txn));
      chk("gcd_a", 64'(gcd_a), 64'(m_a));
      chk("gcd_b", 64'(gcd_b), 64'(m_b));
      if (!m_active && op_valid) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_a      = op_a;
        m_b      = op_b;
        m_byp    = (op_a == '0) || (op_b == '0);
        m_err    = 1'b0;
        if (m_byp) begin
          m_data    = op_a | op_b;
          m_resp_at = cyc + 1;
        end else if (eng_lat != 0 && eng_lat <= TMO) begin
          m_data    = ref_gcd(op_a, op_b);
          m_resp_at = cyc + 2 + eng_lat;
        end else begin
          m_data    = '0;
          m_err     = 1'b1;
          m_resp_at = cyc + 2 + TMO;
        end
      end else if (m_vld && res_ready) begin
        m_active = 1'b0;
        m_txn    = m_txn + CW'(1);
      end
    end
    cyc++;
  end

  // One transaction: returns the result and cycles from accept to res_valid.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                      input int hold, output logic [W-1:0] d, output logic e,
                      output int latency);
    int n;
    @(posedge clk);
    #1;
    eng_lat   = lat;
    op_a      = a;
    op_b      = b;
    op_valid  = 1'b1;
    res_ready = (hold == 0);
    @(negedge clk);
    n = 1;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_bound", 64'(op_ready), 64'(1));
    @(posedge clk);
    #1;
    op_valid = (hold > 0);
    if (hold > 0) begin
      op_a = $urandom;
      op_b = $urandom;
    end
    @(negedge clk);
    n = 1;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("result_bound", 64'(res_valid), 64'(1));
    d       = res_data;
    e       = res_err;
    latency = n;
    $display("txn a=%0d b=%0d lat=%0d hold=%0d -> data=%0d err=%0d cycles=%0d",
             a, b, lat, hold, d, e, n);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      res_ready = 1'b1;
      op_valid  = 1'b0;
    end
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    op_valid  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d, a, b;
    logic e;
    int l, s0, k;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_op_ready", 64'(op_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_txn", 64'(txn_count), 64'(0));
    chk("rst_start", 64'(gcd_start), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));

    // Basic run
    s0 = start_cnt;
    send(48, 18, 5, 0, d, e, l);
    chk("basic_data", 64'(d), 64'(6));
    chk("basic_err", 64'(e), 64'(0));
    chk("basic_lat", 64'(l), 64'(7));
    chk("basic_starts", 64'(start_cnt - s0), 64'(1));
    @(negedge clk);
    chk("basic_txn", 64'(txn_count), 64'(1));

    // Zero bypass
    s0 = start_cnt;
    send(0, 35, 5, 0, d, e, l);
    chk("byp_data", 64'(d), 64'(35));
    chk("byp_lat", 64'(l), 64'(1));
    send(0, 0, 5, 0, d, e, l);
    chk("byp00_data", 64'(d), 64'(0));
    chk("byp00_err", 64'(e), 64'(0));
    chk("byp_starts", 64'(start_cnt - s0), 64'(0));

    // Timeout, then a normal run
    send(100, 60, 0, 0, d, e, l);
    chk("tmo_data", 64'(d), 64'(0));
    chk("tmo_err", 64'(e), 64'(1));
    chk("tmo_lat", 64'(l), 64'(18));
    send(12, 8, 3, 0, d, e, l);
    chk("after_tmo_data", 64'(d), 64'(4));
    chk("after_tmo_err", 64'(e), 64'(0));

    // Done on the last WAIT cycle wins; one cycle later is a timeout
    send(14, 21, 16, 0, d, e, l);
    chk("coll_data", 64'(d), 64'(7));
    chk("coll_err", 64'(e), 64'(0));
    chk("coll_lat", 64'(l), 64'(18));
    send(14, 21, 17, 0, d, e, l);
    chk("late_err", 64'(e), 64'(1));
    chk("late_data", 64'(d), 64'(0));

    // Backpressure
    send(9, 6, 2, 5, d, e, l);
    chk("bp_data", 64'(d), 64'(3));
    @(negedge clk);
    chk("bp_txn", 64'(txn_count), 64'(8));

    // Reset on WAIT cycle 3
    @(posedge clk);
    #1;
    eng_lat  = 10;
    op_a     = 100;
    op_b     = 75;
    op_valid = 1'b1;
    @(negedge clk);
    chk("mr_accept", 64'(op_ready), 64'(1));
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mr_busy_before", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("mr_busy", 64'(busy), 64'(0));
    chk("mr_op_ready", 64'(op_ready), 64'(1));
    chk("mr_res_valid", 64'(res_valid), 64'(0));
    chk("mr_txn", 64'(txn_count), 64'(0));
    chk("mr_start", 64'(gcd_start), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send(270, 192, 4, 0, d, e, l);
    chk("mr_after_data", 64'(d), 64'(6));
    chk("mr_after_err", 64'(e), 64'(0));

    // Random traffic; the model checks every cycle
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = $urandom;
          b = $urandom;
        end
        1: begin
          k = $urandom_range(1, 500);
          a = W'(k * $urandom_range(1, 200));
          b = W'(k * $urandom_range(1, 200));
        end
        2: begin
          a = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom_range(1, 1000));
          b = (a == '0) ? W'($urandom_range(0, 1000)) : '0;
        end
        default: begin
          a = W'($urandom_range(1, 100));
          b = a;
        end
      endcase
      send(a, b, $urandom_range(0, 20), $urandom_range(0, 3), d, e, l);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
